// File: rtl/array_mul_pipe_if.sv
// array_mul_pipe_if: operand/result valid-ready bundle for array_mul_pipe
interface array_mul_pipe_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] product;
  modport master(output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, product);
  modport slave(input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, product);
endinterface

// File: rtl/array_mul_pipe.sv
// array_mul_pipe: pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed
module array_mul_pipe #(
  parameter int WIDTH = 16,
  parameter int ROWS_PER_STAGE = 4
) (
  input logic clk,
  input logic rst_n,
  array_mul_pipe_if.slave bus
);
  localparam int STAGES = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int P = 2 * WIDTH;
  typedef struct packed {
    logic v;
    logic sm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [P-1:0] s;
    logic [P-1:0] c;
  } stg_t;
  stg_t stg [STAGES];
  logic en;
  logic out_valid_q;
  logic [P-1:0] product_q;
  function automatic logic [2*P-1:0] reduce(input stg_t x, input int k);
    logic [P-1:0] s, c, row, t;
    int j;
    s = x.s;
    c = x.c;
    for (int r = 0; r < ROWS_PER_STAGE; r++) begin
      j = k * ROWS_PER_STAGE + r;
      if (j < WIDTH) begin
        row = '0;
        for (int i = 0; i < WIDTH; i++)
          row[i+j] = (x.a[i] & x.b[j]) ^ (x.sm & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
        t = s ^ c ^ row;
        c = ((s & c) | (s & row) | (c & row)) << 1;
        s = t;
      end
    end
    return {s, c};
  endfunction
  assign en = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = rst_n && en;
  assign bus.out_valid = out_valid_q;
  assign bus.product = product_q;
  // Baugh-Wooley constant terms 2^W + 2^(2W-1) seed the sum vector in signed mode
  assign stg[0] = '{
    v: bus.in_valid && bus.in_ready,
    sm: bus.signed_mode,
    a: bus.a,
    b: bus.b,
    s: bus.signed_mode ? ((P'(1) << WIDTH) | (P'(1) << (P - 1))) : '0,
    c: '0
  };
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [2*P-1:0] red;
    assign red = reduce(stg[k], k);
    if (k < STAGES - 1) begin : g_mid
      stg_t stg_d, stg_q;
      assign stg_d = '{v: stg[k].v, sm: stg[k].sm, a: stg[k].a, b: stg[k].b, s: red[2*P-1:P], c: red[P-1:0]};
      always_ff @(posedge clk)
        if (!rst_n) stg_q.v <= 1'b0;
        else if (en) stg_q <= stg_d;
      assign stg[k+1] = stg_q;
    end else begin : g_last
      logic [P-1:0] product_d;
      assign product_d = stg[k].v ? red[2*P-1:P] + red[P-1:0] : product_q;
      always_ff @(posedge clk)
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          product_q <= '0;
        end else if (en) begin
          out_valid_q <= stg[k].v;
          product_q <= product_d;
        end
    end
  end
endmodule

// File: doc/array_mul_pipe.md
ARRAY_MUL_PIPE -- requirements
Module: array_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter ROWS_PER_STAGE, default 4, partial-product array rows evaluated per pipeline stage; legal range 1..WIDTH.
REQ-003 SHALL derive localparam STAGES = ceil(WIDTH/ROWS_PER_STAGE), the pipeline depth.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand set a/b/signed_mode is valid this cycle.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 a  input  WIDTH  multiplicand.
REQ-009 b  input  WIDTH  multiplier.
REQ-010 signed_mode  input  1  1: a, b are two's complement; 0: unsigned; sampled with the operands.
REQ-011 out_valid  output  1  product holds a valid result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 product  output  2*WIDTH  result.

Function
REQ-014 Input handshake SHALL complete on a rising edge with in_valid=1 and in_ready=1; output handshake SHALL complete on a rising edge with out_valid=1 and out_ready=1.
REQ-015 Unsigned mode SHALL produce product = a*b exactly.
REQ-016 Signed mode SHALL produce product = signed(a)*signed(b) in 2*WIDTH-bit two's complement, exact for every input, including a=b=most-negative value.
REQ-017 Datapath SHALL be a carry-save array of AND-generated partial-product rows; stage k (0..STAGES-1) SHALL reduce rows k*ROWS_PER_STAGE up to min((k+1)*ROWS_PER_STAGE, WIDTH)-1.
REQ-018 Signed correction SHALL use Baugh-Wooley sign-bit inversion and constant terms inside the array, not operand pre-negation.
REQ-019 The final stage SHALL include the carry-propagate addition, so product is registered and fully resolved.
REQ-020 Each stage SHALL carry a valid bit, the signed_mode bit, the unconsumed operand bits, and partial sum/carry vectors in registers.
REQ-021 Latency SHALL be exactly STAGES cycles from input handshake to out_valid=1 when no stall occurs.
REQ-022 Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-023 stall = out_valid & ~out_ready; while stall=1, every stage register SHALL hold its value and in_ready SHALL be 0.
REQ-024 in_ready SHALL be ~stall combinationally; bubbles SHALL NOT be collapsed, so the pipeline freezes as a whole.
REQ-025 Results SHALL leave in acceptance order; no operation SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 When out_valid=0, product SHALL hold its last value and SHALL NOT be checked.
REQ-027 Input and output handshakes in the same cycle SHALL both complete, and the pipeline SHALL advance.
REQ-028 in_valid=1 with in_ready=0 SHALL NOT load anything; operands SHALL be resampled when in_ready returns to 1.

Reset
REQ-029 With rst_n=0 at a rising edge, all stage valid bits SHALL clear, out_valid SHALL be 0, and product SHALL be 0 from the next cycle.
REQ-030 in_ready SHALL be 0 while rst_n=0, and SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result for them SHALL appear after reset.
REQ-032 Datapath registers other than product and valid bits need no reset.

Verification (WIDTH=8, ROWS_PER_STAGE=4, STAGES=2)
REQ-033 The bench SHALL cover unsigned a=0xFF, b=0xFF, out_ready=1 -> out_valid exactly 2 cycles after acceptance, product=0xFE01.
REQ-034 The bench SHALL cover signed a=0x80, b=0x7F -> product=0xC080; signed a=0x80, b=0x80 -> product=0x4000; signed a=0xFF, b=0xFF -> product=0x0001.
REQ-035 The bench SHALL cover back-to-back inputs (3,5 unsigned), (0xFE,0x02 signed), (0x10,0x10 unsigned) -> products 0x000F, 0xFFFC, 0x0100 on three consecutive cycles.
REQ-036 The bench SHALL cover out_ready=0 for 3 cycles while a result is valid, with in_valid held 1 -> in_ready=0 for those cycles, product stable, order preserved, no loss afterwards.
REQ-037 The bench SHALL cover rst_n=0 for one cycle, one cycle after accepting 0x0A*0x0B -> out_valid stays 0, 0x006E never appears, in_ready=1 after release.
REQ-038 The bench SHALL cover a random regression of 10k operations, mixed mode and random out_ready, at (WIDTH, ROWS_PER_STAGE) = (8,1), (16,4), (16,16), (13,5) -> all products match the reference model, in order.
